// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing over a shared
// memory, with ready-handshake wait timeout, sticky trap and retire counter.
module multicycle_control #(
  parameter int ALU_OP_WIDTH = 3,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              OP_i,
  input  logic                    Mem_Ready_i,
  output logic                    PC_Write_o,
  output logic                    IR_Write_o,
  output logic                    IorD_o,
  output logic                    Mem_Read_o,
  output logic                    Mem_Write_o,
  output logic                    Reg_Write_o,
  output logic                    ALU_Src_o,
  output logic [ALU_OP_WIDTH-1:0] ALU_Op_o,
  output logic [1:0]              PC_Src_o,
  output logic                    Branch_o,
  output logic [1:0]              Mem_to_Reg_o,
  output logic                    Trap_o,
  output logic [1:0]              Cause_o,
  output logic [CNT_WIDTH-1:0]    Retired_o
);

  localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_I    = 3'd1,
    C_LUI  = 3'd2,
    C_ST   = 3'd3,
    C_LD   = 3'd4,
    C_BR   = 3'd5,
    C_JAL  = 3'd6,
    C_JALR = 3'd7
  } cls_t;

  state_t         state;
  cls_t           cls;
  cls_t           op_cls;
  logic           op_legal;
  logic [WW-1:0]  wait_cnt;
  logic           in_wait;
  logic           timeout;
  logic           trap;
  logic [1:0]     cause;
  logic [CNT_WIDTH-1:0] retired;

  always_comb begin
    op_cls   = C_R;
    op_legal = 1'b1;
    case (OP_i)
      7'b0110011: op_cls = C_R;
      7'b0010011: op_cls = C_I;
      7'b0110111: op_cls = C_LUI;
      7'b0100011: op_cls = C_ST;
      7'b0000011: op_cls = C_LD;
      7'b1100011: op_cls = C_BR;
      7'b1101111: op_cls = C_JAL;
      7'b1100111: op_cls = C_JALR;
      default:    op_legal = 1'b0;
    endcase
  end

  assign in_wait = (state == S_FETCH) || (state == S_MEM);
  assign timeout = (MEM_TIMEOUT != 0) && in_wait && !Mem_Ready_i &&
                   (wait_cnt == WW'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cls      <= C_R;
      wait_cnt <= '0;
      retired  <= '0;
      trap     <= 1'b0;
      cause    <= 2'b00;
    end else begin
      if (in_wait && !Mem_Ready_i && !timeout)
        wait_cnt <= wait_cnt + WW'(1);
      else
        wait_cnt <= '0;

      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (Mem_Ready_i) begin
            cls <= op_cls;
            if (op_legal) begin
              state <= S_DECODE;
            end else begin
              state <= S_TRAP;
              trap  <= 1'b1;
              cause <= 2'b01;
            end
          end else if (timeout) begin
            state <= S_TRAP;
            trap  <= 1'b1;
            cause <= 2'b10;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          case (cls)
            C_LD, C_ST: state <= S_MEM;
            C_BR: begin
              state   <= S_FETCH;
              retired <= retired + CNT_WIDTH'(1);
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (Mem_Ready_i) begin
            if (cls == C_LD) begin
              state <= S_WB;
            end else begin
              state   <= S_FETCH;
              retired <= retired + CNT_WIDTH'(1);
            end
          end else if (timeout) begin
            state <= S_TRAP;
            trap  <= 1'b1;
            cause <= 2'b10;
          end
        end
        S_WB: begin
          state   <= S_FETCH;
          retired <= retired + CNT_WIDTH'(1);
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode; FETCH strobes qualify on the ready handshake
  always_comb begin
    PC_Write_o   = 1'b0;
    IR_Write_o   = 1'b0;
    IorD_o       = 1'b0;
    Mem_Read_o   = 1'b0;
    Mem_Write_o  = 1'b0;
    Reg_Write_o  = 1'b0;
    ALU_Src_o    = 1'b0;
    ALU_Op_o     = '0;
    PC_Src_o     = 2'b00;
    Branch_o     = 1'b0;
    Mem_to_Reg_o = 2'b00;
    case (state)
      S_FETCH: begin
        Mem_Read_o = 1'b1;
        if (Mem_Ready_i) begin
          IR_Write_o = 1'b1;
          PC_Write_o = 1'b1;
        end
      end
      S_EXEC: begin
        ALU_Op_o  = ALU_OP_WIDTH'(cls);
        ALU_Src_o = (cls == C_I) || (cls == C_LUI) || (cls == C_LD) ||
                    (cls == C_ST) || (cls == C_JALR);
        case (cls)
          C_BR: begin
            Branch_o = 1'b1;
            PC_Src_o = 2'b01;
          end
          C_JAL: begin
            PC_Write_o = 1'b1;
            PC_Src_o   = 2'b01;
          end
          C_JALR: begin
            PC_Write_o = 1'b1;
            PC_Src_o   = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        IorD_o      = 1'b1;
        Mem_Read_o  = (cls == C_LD);
        Mem_Write_o = (cls == C_ST);
      end
      S_WB: begin
        Reg_Write_o = 1'b1;
        case (cls)
          C_LD:          Mem_to_Reg_o = 2'b01;
          C_JAL, C_JALR: Mem_to_Reg_o = 2'b10;
          default:       Mem_to_Reg_o = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  assign Trap_o    = trap;
  assign Cause_o   = cause;
  assign Retired_o = retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: instruction classes,
// wait states, traps, timeout boundary, counter wrap and async reset.
module tb_multicycle_control;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = '0;
  logic       rdy = 1'b0;

  logic       pcw, irw, iord, mrd, mwr, rw, asrc, br, trap;
  logic [2:0] aop;
  logic [1:0] pcs, m2r, cause;
  logic [3:0] retired;
  logic [15:0] obs;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control #(
    .ALU_OP_WIDTH(3),
    .MEM_TIMEOUT (15),
    .CNT_WIDTH   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .OP_i        (op),
    .Mem_Ready_i (rdy),
    .PC_Write_o  (pcw),
    .IR_Write_o  (irw),
    .IorD_o      (iord),
    .Mem_Read_o  (mrd),
    .Mem_Write_o (mwr),
    .Reg_Write_o (rw),
    .ALU_Src_o   (asrc),
    .ALU_Op_o    (aop),
    .PC_Src_o    (pcs),
    .Branch_o    (br),
    .Mem_to_Reg_o(m2r),
    .Trap_o      (trap),
    .Cause_o     (cause),
    .Retired_o   (retired)
  );

  assign obs = {pcw, irw, iord, mrd, mwr, rw, asrc, aop, pcs, br, m2r};

  function automatic logic [15:0] ctl(
    input logic f_pcw, input logic f_irw, input logic f_iord,
    input logic f_mrd, input logic f_mwr, input logic f_rw,
    input logic f_asrc, input logic [2:0] f_aop,
    input logic [1:0] f_pcs, input logic f_br, input logic [1:0] f_m2r);
    return {f_pcw, f_irw, f_iord, f_mrd, f_mwr, f_rw, f_asrc,
            f_aop, f_pcs, f_br, f_m2r};
  endfunction

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [6:0] o);
    @(posedge clk);
    #2;
    rdy = r;
    op  = o;
    #1;
  endtask

  task automatic run_r();
    step(1'b1, OP_R);
    step(1'b1, OP_R);
    step(1'b1, OP_R);
    step(1'b1, OP_R);
  endtask

  logic [15:0] f_rdy, f_wait, wb_alu, wb_ld, wb_j;

  initial begin
    f_rdy  = ctl(1,1,0,1,0,0,0,3'b000,2'b00,0,2'b00);
    f_wait = ctl(0,0,0,1,0,0,0,3'b000,2'b00,0,2'b00);
    wb_alu = ctl(0,0,0,0,0,1,0,3'b000,2'b00,0,2'b00);
    wb_ld  = ctl(0,0,0,0,0,1,0,3'b000,2'b00,0,2'b01);
    wb_j   = ctl(0,0,0,0,0,1,0,3'b000,2'b00,0,2'b10);

    #12;
    check("rst_ctl", obs, 16'h0);
    check("rst_trap", 16'(trap), 16'h0);
    check("rst_cause", 16'(cause), 16'h0);
    check("rst_ret", 16'(retired), 16'h0);
    reset = 1'b1;
    rdy   = 1'b1;
    op    = OP_R;

    step(1'b1, OP_R);  check("r_fetch", obs, f_rdy);
    check("r_ret0", 16'(retired), 16'd0);
    step(1'b1, OP_R);  check("r_dec", obs, 16'h0);
    step(1'b1, OP_R);  check("r_exec", obs, 16'h0);
    step(1'b1, OP_R);  check("r_wb", obs, wb_alu);

    step(1'b1, OP_LD); check("ld_fetch", obs, f_rdy);
    check("ld_ret", 16'(retired), 16'd1);
    step(1'b1, OP_LD); check("ld_dec", obs, 16'h0);
    step(1'b1, OP_LD);
    check("ld_exec", obs, ctl(0,0,0,0,0,0,1,3'b100,2'b00,0,2'b00));
    for (int i = 0; i < 4; i++) begin
      step(i == 3, OP_LD);
      check("ld_mem", obs, ctl(0,0,1,1,0,0,0,3'b000,2'b00,0,2'b00));
    end
    step(1'b1, OP_LD); check("ld_wb", obs, wb_ld);
    check("ld_wb_ret", 16'(retired), 16'd1);

    step(1'b1, OP_ST); check("st_fetch", obs, f_rdy);
    check("st_ret", 16'(retired), 16'd2);
    step(1'b1, OP_ST); check("st_dec", obs, 16'h0);
    step(1'b1, OP_ST);
    check("st_exec", obs, ctl(0,0,0,0,0,0,1,3'b011,2'b00,0,2'b00));
    step(1'b1, OP_ST);
    check("st_mem", obs, ctl(0,0,1,0,1,0,0,3'b000,2'b00,0,2'b00));

    step(1'b1, OP_BR); check("br_fetch", obs, f_rdy);
    check("br_ret", 16'(retired), 16'd3);
    step(1'b1, OP_BR); check("br_dec", obs, 16'h0);
    step(1'b1, OP_BR);
    check("br_exec", obs, ctl(0,0,0,0,0,0,0,3'b101,2'b01,1,2'b00));

    step(1'b1, OP_JAL); check("jal_fetch", obs, f_rdy);
    check("jal_ret", 16'(retired), 16'd4);
    step(1'b1, OP_JAL); check("jal_dec", obs, 16'h0);
    step(1'b1, OP_JAL);
    check("jal_exec", obs, ctl(1,0,0,0,0,0,0,3'b110,2'b01,0,2'b00));
    step(1'b1, OP_JAL); check("jal_wb", obs, wb_j);

    step(1'b1, OP_JALR); check("jalr_fetch", obs, f_rdy);
    check("jalr_ret", 16'(retired), 16'd5);
    step(1'b1, OP_JALR); check("jalr_dec", obs, 16'h0);
    step(1'b1, OP_JALR);
    check("jalr_exec", obs, ctl(1,0,0,0,0,0,1,3'b111,2'b10,0,2'b00));
    step(1'b1, OP_JALR); check("jalr_wb", obs, wb_j);

    step(1'b1, OP_I); check("i_fetch", obs, f_rdy);
    check("i_ret", 16'(retired), 16'd6);
    step(1'b1, OP_I); check("i_dec", obs, 16'h0);
    step(1'b1, OP_I);
    check("i_exec", obs, ctl(0,0,0,0,0,0,1,3'b001,2'b00,0,2'b00));
    step(1'b1, OP_I); check("i_wb", obs, wb_alu);

    step(1'b1, OP_LUI); check("lui_fetch", obs, f_rdy);
    check("lui_ret", 16'(retired), 16'd7);
    step(1'b1, OP_LUI); check("lui_dec", obs, 16'h0);
    step(1'b1, OP_LUI);
    check("lui_exec", obs, ctl(0,0,0,0,0,0,1,3'b010,2'b00,0,2'b00));
    step(1'b1, OP_LUI); check("lui_wb", obs, wb_alu);

    step(1'b1, OP_BAD); check("bad_fetch", obs, f_rdy);
    check("bad_ret", 16'(retired), 16'd8);
    for (int i = 0; i < 20; i++) begin
      step(1'(i), (i % 2 == 0) ? OP_R : OP_LD);
      check("ill_ctl", obs, 16'h0);
      check("ill_trap", 16'(trap), 16'h1);
      check("ill_cause", 16'(cause), 16'h1);
    end
    check("ill_ret", 16'(retired), 16'd8);

    #2 reset = 1'b0;
    #1;
    check("rst2_trap", 16'(trap), 16'h0);
    check("rst2_cause", 16'(cause), 16'h0);
    check("rst2_ret", 16'(retired), 16'h0);
    check("rst2_ctl", obs, 16'h0);
    rdy   = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(1'b0, OP_R);
      check("to_wait", obs, f_wait);
      check("to_notrap", 16'(trap), 16'h0);
    end
    step(1'b0, OP_R);
    check("to_trap", 16'(trap), 16'h1);
    check("to_cause", 16'(cause), 16'h2);
    check("to_ctl", obs, 16'h0);

    #2 reset = 1'b0;
    #1 rdy = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, OP_R);
      check("edge_wait", obs, f_wait);
    end
    step(1'b1, OP_R); check("edge_fetch", obs, f_rdy);
    step(1'b1, OP_R); check("edge_notrap", 16'(trap), 16'h0);
    check("edge_dec", obs, 16'h0);
    step(1'b1, OP_R); check("edge_exec", obs, 16'h0);
    step(1'b1, OP_R); check("edge_wb", obs, wb_alu);
    step(1'b1, OP_R); check("edge_ret", 16'(retired), 16'd1);

    #2 reset = 1'b0;
    #1 reset = 1'b1;
    for (int i = 0; i < 17; i++) run_r();
    step(1'b1, OP_JAL); check("wrap_ret", 16'(retired), 16'd1);
    step(1'b1, OP_JAL); check("wrap_dec", obs, 16'h0);
    step(1'b1, OP_JAL);
    check("wrap_exec", obs, ctl(1,0,0,0,0,0,0,3'b110,2'b01,0,2'b00));
    #2 reset = 1'b0;
    #1;
    check("async_ctl", obs, 16'h0);
    check("async_ret", 16'(retired), 16'h0);
    reset = 1'b1;
    step(1'b0, OP_R); check("post_fetch", obs, f_wait);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle control unit for the RISC-V core, for use with a shared instruction/data memory. It replaces single-cycle opcode decode with a state machine that sequences fetch, decode, execute, memory and writeback. Memory access uses a ready handshake with a wait-state timeout, and the block sticky-traps on illegal opcodes or memory timeouts. It also keeps a retired-instruction counter.

Parameters:
ALU_OP_WIDTH, 3, width of the ALU_Op_o class code.
MEM_TIMEOUT, 15, maximum consecutive not-ready cycles in a memory state before trapping; 0 disables the timeout.
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
OP_i  input  7  opcode field from memory read data (instruction bus), sampled in FETCH.
Mem_Ready_i  input  1  memory completes the current access this cycle.
PC_Write_o  output  1  PC register load enable.
IR_Write_o  output  1  instruction register load enable.
IorD_o  output  1  memory address select: 0 = PC, 1 = ALU result register.
Mem_Read_o  output  1  memory read request.
Mem_Write_o  output  1  memory write request.
Reg_Write_o  output  1  register file write enable.
ALU_Src_o  output  1  ALU operand B: 0 = rs2, 1 = immediate.
ALU_Op_o  output  ALU_OP_WIDTH  instruction class code for ALU control; meaningful only in EXEC.
PC_Src_o  output  2  PC source: 00 = PC+4, 01 = branch/JAL target, 10 = JALR target (rs1+imm).
Branch_o  output  1  conditional PC load; the datapath gates it with the compare result.
Mem_to_Reg_o  output  2  writeback source: 00 = ALU, 01 = memory data, 10 = PC+4.
Trap_o  output  1  sticky trap flag.
Cause_o  output  2  trap cause: 00 = none, 01 = illegal opcode, 10 = memory timeout.
Retired_o  output  CNT_WIDTH  count of completed instructions.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; latched opcode class is cleared; wait counter and Retired_o go to 0; Trap_o=0; Cause_o=00.
  - Every control output is 0 while in IDLE.
- IDLE -> FETCH unconditionally on the first clock edge after reset deasserts.
- Outputs are Moore outputs, decoded from the current state and the latched class. Any output not listed for a state is 0.
- Opcode classes and ALU_Op_o codes:
  - R 0110011 = 000
  - I-logic 0010011 = 001
  - LUI 0110111 = 010
  - Store 0100011 = 011
  - Load 0000011 = 100
  - Branch 1100011 = 101
  - JAL 1101111 = 110
  - JALR 1100111 = 111
- FETCH: Mem_Read_o=1, IorD_o=0.
  - If Mem_Ready_i=1: IR_Write_o=1, PC_Write_o=1, PC_Src_o=00; OP_i is latched; next state is DECODE, or TRAP (cause 01) if OP_i is not one of the eight opcodes.
  - If Mem_Ready_i=0: stay in FETCH.
- DECODE: no control outputs active; next state EXEC.
- EXEC: ALU_Op_o = class code. ALU_Src_o=1 for I-logic, LUI, Load, Store and JALR; 0 otherwise. Next state by class:
  - R, I-logic, LUI: next WB.
  - Load, Store: next MEM.
  - Branch: Branch_o=1, PC_Src_o=01; next FETCH (instruction retires).
  - JAL: PC_Write_o=1, PC_Src_o=01; next WB.
  - JALR: PC_Write_o=1, PC_Src_o=10; next WB.
- MEM: IorD_o=1; Mem_Read_o=1 for Load, Mem_Write_o=1 for Store.
  - On Mem_Ready_i=1: Load goes to WB; Store goes to FETCH (retires).
  - On Mem_Ready_i=0: stay in MEM.
- WB: Reg_Write_o=1. Mem_to_Reg_o = 01 for Load, 10 for JAL/JALR, 00 otherwise. Next FETCH (retires).
- Retired_o increments by 1 on each retiring transition into FETCH. It wraps from all-ones to 0 and is never incremented on entry to TRAP.
- Wait counter:
  - Increments each cycle the FSM is in FETCH or MEM with Mem_Ready_i=0.
  - Clears on Mem_Ready_i=1 or on leaving the state.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT while Mem_Ready_i=0: next state TRAP, Cause_o=10.
  - Mem_Ready_i=1 on the same cycle wins over the timeout.
- TRAP: all control outputs 0; Trap_o=1; Cause_o is held. The FSM stays in TRAP until reset; OP_i and Mem_Ready_i are ignored.
- Reset asserted in any state aborts the instruction immediately: no partial register write, and Retired_o is cleared.

Test Plan:
- R-type add (OP_i=0110011), Mem_Ready_i always 1 -> IDLE, FETCH, DECODE, EXEC (ALU_Op_o=000), WB (Reg_Write_o=1, Mem_to_Reg_o=00); Retired_o=1 after 5 cycles from reset release.
- Load (0000011), Mem_Ready_i low 3 cycles in MEM -> MEM held 4 cycles with IorD_o=1, Mem_Read_o=1; WB with Mem_to_Reg_o=01; Retired_o increments once.
- Sequence Store, Branch, JAL, JALR -> Store skips WB; Branch shows Branch_o=1, PC_Src_o=01; JAL/JALR show PC_Src_o 01/10 in EXEC and Mem_to_Reg_o=10 in WB; Retired_o=4.
- OP_i=1111111 fetched -> TRAP, Trap_o=1, Cause_o=01, all outputs 0 for 20 further cycles; reset pulse returns to IDLE with Cause_o=00.
- MEM_TIMEOUT=15, Mem_Ready_i held 0 in FETCH -> TRAP with Cause_o=10 after 16 cycles in FETCH. Repeat with Mem_Ready_i=1 on the 16th cycle -> DECODE, no trap.
- CNT_WIDTH=4, 17 R-type instructions -> Retired_o wraps to 1; reset asserted mid-EXEC -> outputs 0 asynchronously, Retired_o=0.
